// File: rtl/word_assembler.sv
// word_assembler: collects four lane-addressed words into one frame on a valid/ready output,
// flagging misaligned or duplicate lane writes and counting released frames.
module word_assembler #(
   parameter int WORD_W = 32,
   parameter int LANES  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WORD_W-1:0]         in_data,
   input  logic [3:0]                in_addr,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WORD_W*LANES-1:0]   out_data,
   output logic                      err,
   output logic [7:0]                frame_cnt
);
   logic [LANES-1:0]        mask_q, mask_d, mask_base;
   logic [WORD_W*LANES-1:0] data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    err_q, err_d;
   logic [7:0]              cnt_q, cnt_d;
   logic                    fire_out, accept;
   logic [1:0]              lane;
   assign lane      = in_addr[3:2];
   assign in_ready  = !valid_q || out_ready;
   assign fire_out  = valid_q && out_ready;
   assign accept    = in_valid && in_ready;
   // a release in the same cycle frees every lane before the incoming word lands
   assign mask_base = fire_out ? '0 : mask_q;
   always_comb begin
      mask_d = mask_base;
      data_d = data_q;
      err_d  = 1'b0;
      cnt_d  = cnt_q + {7'd0, fire_out};
      if (accept && in_addr[1:0] != 2'b00) begin
         err_d = 1'b1;
      end else if (accept) begin
         data_d[lane*WORD_W +: WORD_W] = in_data;
         err_d                         = mask_base[lane];
         mask_d[lane]                  = 1'b1;
      end
      valid_d = &mask_d;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mask_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         mask_q  <= mask_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign err       = err_q;
   assign frame_cnt = cnt_q;
endmodule
